// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_DIV = 3'b100;
    localparam logic [2:0] ALU_ILL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// acc holds the product high word or the partial remainder; shreg the low word or quotient.
module seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             is_div;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] shreg_n;

    always_comb begin
        sum     = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        shifted = {acc, shreg[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_n   = sum[WIDTH:1];
        shreg_n = {sum[0], shreg[WIDTH-1:1]};
        if (is_div) begin
            // A clear borrow bit means the shifted remainder covers the divisor.
            if (!diff[WIDTH]) begin
                acc_n   = diff[WIDTH-1:0];
                shreg_n = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_n   = shifted[WIDTH-1:0];
                shreg_n = {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            shreg  <= '0;
            opnd   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            is_div <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= '0;
                shreg  <= a;
                opnd   <= b;
                cnt    <= CNT_W'(WIDTH - 1);
                busy   <= 1'b1;
                is_div <= op_div;
            end else if (busy) begin
                acc   <= acc_n;
                shreg <= shreg_n;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    assign lo = shreg;
    assign hi = acc;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative mul/div behind
// valid/ready handshakes, with registered result, high word and flags.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             err
);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             start;
    logic             load;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             res_err;
    logic             slt_bit;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign slt_bit  = $signed(a) < $signed(b);
    assign zero     = (out == '0);

    seq_muldiv #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_div (alu_ctrl == ALU_DIV),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_comb begin
        state_n = state;
        start   = 1'b0;
        load    = 1'b0;
        res_lo  = '0;
        res_hi  = '0;
        res_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    case (alu_ctrl)
                        ALU_AND: res_lo = a & b;
                        ALU_OR:  res_lo = a | b;
                        ALU_ADD: res_lo = a + b;
                        ALU_SUB: res_lo = a - b;
                        ALU_SLT: res_lo = {{(WIDTH-1){1'b0}}, slt_bit};
                        ALU_MUL: begin
                            load    = 1'b0;
                            start   = 1'b1;
                            state_n = S_MUL;
                        end
                        ALU_DIV: begin
                            // Divide-by-zero is resolved immediately without iterating.
                            if (b == '0) begin
                                res_lo  = '1;
                                res_hi  = a;
                                res_err = 1'b1;
                            end else begin
                                load    = 1'b0;
                                start   = 1'b1;
                                state_n = S_DIV;
                            end
                        end
                        default: res_err = 1'b1;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (md_done) begin
                    load    = 1'b1;
                    res_lo  = md_lo;
                    res_hi  = md_hi;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out       <= '0;
            out_hi    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                out       <= res_lo;
                out_hi    <= res_hi;
                err       <= res_err;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu with hand-computed expected values.
module tb_mc_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [31:0] out_hi;
    logic        zero;
    logic        err;

    int checks;
    int failures;
    int cycles;
    bit saw_ready;
    bit saw_valid;
    logic [31:0] held;

    mc_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one operation for a single edge; in_ready is checked just before it.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        in_valid = 1'b1;
        alu_ctrl = op;
        a        = av;
        b        = bv;
        #1;
        checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int n, output bit ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (n < 100) begin
            tick();
            n++;
            if (out_valid) break;
            if (in_ready) ready_seen = 1'b1;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        alu_ctrl  = 3'b000;
        tick();
        tick();
        checkOutput("rst_out",       out, 32'h0);
        checkOutput("rst_out_hi",    out_hi, 32'h0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_err",       {31'b0, err}, 32'd0);
        checkOutput("rst_zero",      {31'b0, zero}, 32'd1);
        rst = 1'b0;
        tick();

        applyStimulus("add", 3'b010, 32'h7FFF_FFFF, 32'h1);
        checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_out",   out, 32'h8000_0000);
        checkOutput("add_hi",    out_hi, 32'h0);
        checkOutput("add_zero",  {31'b0, zero}, 32'd0);
        checkOutput("add_err",   {31'b0, err}, 32'd0);
        tick();
        checkOutput("add_consumed", {31'b0, out_valid}, 32'd0);

        // Operands are scrambled after acceptance to prove they were latched.
        applyStimulus("mul", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        a = 32'h1234_5678;
        b = 32'h0000_0002;
        alu_ctrl = 3'b000;
        waitResult(cycles, saw_ready);
        checkOutput("mul_latency", cycles, 32'd33);
        checkOutput("mul_busy",    {31'b0, saw_ready}, 32'd0);
        checkOutput("mul_hi",      out_hi, 32'hFFFF_FFFE);
        checkOutput("mul_lo",      out, 32'h0000_0001);

        applyStimulus("div", 3'b100, 32'd100, 32'd7);
        waitResult(cycles, saw_ready);
        checkOutput("div_latency", cycles, 32'd33);
        checkOutput("div_quot",    out, 32'd14);
        checkOutput("div_rem",     out_hi, 32'd2);
        checkOutput("div_err",     {31'b0, err}, 32'd0);

        applyStimulus("div0", 3'b100, 32'd5, 32'd0);
        checkOutput("div0_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("div0_out",   out, 32'hFFFF_FFFF);
        checkOutput("div0_hi",    out_hi, 32'd5);
        checkOutput("div0_err",   {31'b0, err}, 32'd1);

        applyStimulus("slt", 3'b111, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_out", out, 32'd1);
        checkOutput("slt_hi",  out_hi, 32'd0);
        checkOutput("slt_err", {31'b0, err}, 32'd0);

        applyStimulus("sub", 3'b110, 32'd5, 32'd5);
        checkOutput("sub_out",  out, 32'd0);
        checkOutput("sub_zero", {31'b0, zero}, 32'd1);

        applyStimulus("ill", 3'b101, 32'h55, 32'hAA);
        checkOutput("ill_out",  out, 32'd0);
        checkOutput("ill_hi",   out_hi, 32'd0);
        checkOutput("ill_err",  {31'b0, err}, 32'd1);
        checkOutput("ill_zero", {31'b0, zero}, 32'd1);

        applyStimulus("or", 3'b001, 32'h0000_00F0, 32'h0000_000F);
        out_ready = 1'b0;
        checkOutput("or_out", out, 32'h0000_00FF);
        checkOutput("or_err", {31'b0, err}, 32'd0);
        held = out;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_out",      out, held);
            checkOutput("bp_valid",    {31'b0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        applyStimulus("and", 3'b000, 32'hFF00_FF00, 32'h0F0F_0F0F);
        checkOutput("and_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("and_out",   out, 32'h0F00_0F00);

        applyStimulus("mul_rst", 3'b011, 32'h1234_5678, 32'd3);
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_out",   out, 32'h0);
        checkOutput("arst_hi",    out_hi, 32'h0);
        checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_zero",  {31'b0, zero}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("abort_no_valid", {31'b0, saw_valid}, 32'd0);

        applyStimulus("add2", 3'b010, 32'd2, 32'd3);
        checkOutput("add2_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add2_out",   out, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Parametrised multi-cycle successor to the processor's combinational ALU.
- Executes add, sub, and, or and slt in one cycle. Executes unsigned multiply (shift-add) and unsigned divide (restoring) iteratively, one bit per cycle.
- Uses a valid/ready handshake on both input and output, so the datapath can stall on long operations.
- Returns the full product (hi/lo) and the remainder, in addition to the zero and error flags.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A (dividend for div).
- b  in  WIDTH  operand B (divisor for div).
- alu_ctrl  in  3  opcode: 000 and, 001 or, 010 add, 110 sub, 111 slt, 011 mul, 100 div, 101 illegal.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result: sum, difference, logic, slt, product low, or quotient.
- out_hi  out  WIDTH  product high word (mul), remainder (div), 0 for all other ops.
- zero  out  1  out == 0 (low word only).
- err  out  1  set for divide-by-zero or illegal opcode.

Behaviour:
- Reset (async, any state): state=IDLE; out, out_hi, out_valid and err = 0; zero = 1; counter and internal accumulators = 0. An operation in flight is aborted and never reported.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back issue when the result is consumed in the same cycle.
- An operation is accepted on in_valid && in_ready. Operands and opcode are latched at acceptance, so later changes to a, b or alu_ctrl are ignored.
- States:
  - IDLE: accepts work.
  - MUL and DIV: one iteration per cycle; counter counts from WIDTH-1 down to 0.
  - IDLE is re-entered on completion; the result is held in output registers.
- Latency from the acceptance edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - mul and div: WIDTH+1 cycles.
  - Divide-by-zero and illegal opcode: 1 cycle.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow flag.
  - slt is signed two's complement; out = {0…,1} or 0; out_hi = 0.
  - mul is unsigned; {out_hi,out} = a*b, 2*WIDTH bits exact.
  - div is unsigned; out = a/b, out_hi = a%b.
- Divide by zero: out = all ones, out_hi = a, err = 1.
- Illegal opcode 101: out = 0, out_hi = 0, err = 1, zero = 1.
- err is cleared on the next accepted operation that produces no error.
- zero is computed from the registered out and updates with out.
- Output hold: out, out_hi, zero and err remain stable while out_valid && !out_ready.
- out_valid falls the cycle after out_ready is sampled high, unless a new single-cycle op is accepted in that same cycle. In that case out_valid stays high with the new result.
- in_valid while busy is ignored (in_ready = 0); there is no queueing.
- Counter wrap: the MUL/DIV exit is taken exactly when counter == 0. The counter never underflows.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, ALU_DIV);
  - the state encoding (S_IDLE, S_MUL, S_DIV).
- One sub-module, seq_muldiv, holds the shared shift register, accumulator and counter for the iterative mul/div datapath. It has its own start/done pins.
- The top level keeps the single-cycle ops, the handshake and the output registers.

Test Plan:
- add, a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle later; out=0x80000000, zero=0, err=0.
- mul, a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid after 33 cycles; out_hi=0xFFFFFFFE, out=0x00000001. in_ready stays 0 during the iteration.
- div, a=100, b=7, then a=5, b=0 -> first result out=14, out_hi=2, err=0. Second result, 1 cycle later: out=0xFFFFFFFF, out_hi=5, err=1.
- slt, a=0xFFFFFFFF (−1), b=1 -> out=1. sub, a=5, b=5 -> out=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an or result -> out stays stable and in_ready=0. Raising out_ready with in_valid (and) set accepts the new op in that same cycle.
- Assert rst midway (cycle 10) through a mul -> outputs clear asynchronously with no out_valid. After release, add 2+3 -> out=5.
